bit_deserializer: RTL and testbench



---
 rtl/bit_deserializer.sv | 152 +++++++++++++++
 tb/tb_bit_deserializer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_deserializer.sv
// -----------------------------------------------------------------------------
// bit_deserializer
//
// Purpose:
//   Serial-to-parallel front stage for the N-bit bit-order reverser. Collects a
//   1-bit serial stream into N-bit words and presents each finished word on a
//   valid/ready output. m_valid is wired straight to the reverser's enable.
//   A start-of-frame flag (s_sof) realigns the word boundary: any partial word
//   in progress is thrown away and counted in a saturating drop counter.
//   The shift register plus a one-word output register sustain 1 bit/cycle
//   with lossless backpressure.
//
// Configuration macro:
//   DESER_MSB_FIRST_EN  defined   -> first bit of a word lands in m_data[N-1]
//                       undefined -> first bit of a word lands in m_data[0]
//
// Parameters:
//   N       parallel word width (2..32)
//   DROP_W  width of the saturating dropped-partial-word counter
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   s_valid   serial bit valid
//   s_ready   stage can accept s_data this cycle (combinational)
//   s_data    serial data bit
//   s_sof     start of frame; this bit becomes bit 0 of a new word
//   m_valid   m_data holds a complete word
//   m_ready   downstream accepts the word
//   m_data    assembled word
//   drop_cnt  number of partial words discarded by s_sof (saturating)
// -----------------------------------------------------------------------------
module bit_deserializer #(
  parameter int N      = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_data,
  input  logic              s_sof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N-1:0]      m_data,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CW = $clog2(N);

  localparam logic [CW-1:0]     LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0]     ONE_IDX  = CW'(1);
  localparam logic [CW-1:0]     ZERO_IDX = '0;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

`ifdef DESER_MSB_FIRST_EN
  localparam logic [CW-1:0] FIRST_POS = LAST_IDX;
`else
  localparam logic [CW-1:0] FIRST_POS = ZERO_IDX;
`endif

  logic [N-1:0]      shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]      m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic          acc;
  logic          cnt_last;
  logic          load_word;
  logic [CW-1:0] cnt_pos;
  logic [CW-1:0] write_pos;

  // The completing bit is the only one that needs room in the output register;
  // partial bits are always taken. m_ready feeds s_ready combinationally so a
  // draining word and a newly completed word can swap on the same edge.
  assign cnt_last = (cnt_q == LAST_IDX);
  assign s_ready  = !cnt_last || !m_valid_q || m_ready;
  assign acc      = s_valid && s_ready;

  // A sof bit on the last slot is a realignment, not a completion.
  assign load_word = acc && cnt_last && !s_sof;

  // Map the in-word bit index to a physical shift register slot. A sof bit
  // always goes to the first slot of the word regardless of cnt.
  always_comb begin
`ifdef DESER_MSB_FIRST_EN
    cnt_pos = LAST_IDX - cnt_q;
`else
    cnt_pos = cnt_q;
`endif
    write_pos = s_sof ? FIRST_POS : cnt_pos;
  end

  // Next-state logic. Stale bits left in the shift register from a finished
  // or discarded word are harmless: every slot is rewritten before the next
  // word is loaded into the output register.
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    drop_d    = drop_q;

    if (acc) begin
      shift_d[write_pos] = s_data;
      if (s_sof) begin
        cnt_d = ONE_IDX;
        if ((cnt_q != ZERO_IDX) && (drop_q != DROP_MAX)) begin
          drop_d = drop_q + 1'b1;
        end
      end else if (cnt_last) begin
        cnt_d = ZERO_IDX;
      end else begin
        cnt_d = cnt_q + ONE_IDX;
      end
    end

    // A new load wins over a drain so a simultaneous transfer+load leaves
    // m_valid high with no bubble. load_word can only happen when the output
    // register is empty or draining, which keeps held data stable.
    if (load_word) begin
      m_data_d  = shift_d;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a partial word in flight at reset
  // is discarded without being counted as a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      drop_q    <= drop_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// -----------------------------------------------------------------------------
// tb_bit_deserializer
//
// Self-checking bench for bit_deserializer (N=4, DROP_W=8). Expected words are
// pushed to a scoreboard queue when their completing bit is driven and popped
// whenever the DUT transfers a word (m_valid && m_ready). Works with or without
// DESER_MSB_FIRST_EN defined.
// -----------------------------------------------------------------------------
module tb_bit_deserializer;

  localparam int N      = 4;
  localparam int DROP_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic              s_data;
  logic              s_sof;
  logic              m_valid;
  logic              m_ready;
  logic [N-1:0]      m_data;
  logic [DROP_W-1:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] expQ[$];

  typedef struct {
    logic [N-1:0] seq;
    logic [N-1:0] expLsb;
    logic [N-1:0] expMsb;
  } vec_t;

  vec_t vecTable[7];

  bit           prevHold = 1'b0;
  logic [N-1:0] prevData = '0;

  bit_deserializer #(.N(N), .DROP_W(DROP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_sof    (s_sof),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Select the expected word for the bit order this build was compiled with.
  function automatic logic [N-1:0] pick(input logic [N-1:0] lsb, input logic [N-1:0] msb);
`ifdef DESER_MSB_FIRST_EN
    return msb;
`else
    return lsb;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one bit and wait (bounded) until it is accepted. Returns at
  // posedge+1 after the accepting edge, with s_valid dropped.
  task automatic applyStimulus(input logic d, input logic sof, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got s_ready=%b expected 1 at %0t", s_ready, $time);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 1'b0;
    s_sof   = 1'b0;
  endtask

  // Scoreboard: every transfer must match the oldest outstanding word.
  always @(negedge clk) begin
    if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_word: got 0x%0h expected none at %0t", m_data, $time);
      end else begin
        checkOutput("word", 32'(m_data), 32'(expQ.pop_front()));
      end
    end
  end

  // While the output is stalled, m_data and m_valid must not move.
  always @(negedge clk) begin
    if (!rst && prevHold) begin
      checkOutput("hold_valid", 32'(m_valid), 32'd1);
      checkOutput("hold_data", 32'(m_data), 32'(prevData));
    end
    prevHold = !rst && (m_valid === 1'b1) && (m_ready === 1'b0);
    prevData = m_data;
  end

  initial begin
    int w;

    vecTable[0] = '{4'b1101, 4'hD, 4'hB};
    vecTable[1] = '{4'b0001, 4'h1, 4'h8};
    vecTable[2] = '{4'b0110, 4'h6, 4'h6};
    vecTable[3] = '{4'b1111, 4'hF, 4'hF};
    vecTable[4] = '{4'b0000, 4'h0, 4'h0};
    vecTable[5] = '{4'b0100, 4'h4, 4'h2};
    vecTable[6] = '{4'b1010, 4'hA, 4'h5};

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 1'b0;
    s_sof   = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_m_data", 32'(m_data), 32'd0);
    checkOutput("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("reset_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back words with m_ready=1: no stalls, m_valid one cycle per word.
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < N; b++) begin
        if (b == N - 1) expQ.push_back(pick(vecTable[i].expLsb, vecTable[i].expMsb));
        applyStimulus(vecTable[i].seq[b], 1'b0, w);
        checkOutput("stream_wait", 32'(w), 32'd0);
        if (b == 0 && i > 0) checkOutput("valid_one_cycle", 32'(m_valid), 32'd0);
      end
      checkOutput("valid_latency", 32'(m_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    checkOutput("valid_drained", 32'(m_valid), 32'd0);
    checkOutput("no_drop_stream", 32'(drop_cnt), 32'd0);

    // Backpressure: 1,0,1,1 held, then 0,1,1 accepted, 8th bit stalls.
    m_ready = 1'b0;
    expQ.push_back(pick(4'hD, 4'hB));
    applyStimulus(1'b1, 1'b0, w);
    applyStimulus(1'b0, 1'b0, w);
    applyStimulus(1'b1, 1'b0, w);
    applyStimulus(1'b1, 1'b0, w);
    applyStimulus(1'b0, 1'b0, w);
    checkOutput("bp_bit5_wait", 32'(w), 32'd0);
    applyStimulus(1'b1, 1'b0, w);
    applyStimulus(1'b1, 1'b0, w);
    checkOutput("bp_bit7_wait", 32'(w), 32'd0);
    checkOutput("bp_held_data", 32'(m_data), 32'(pick(4'hD, 4'hB)));
    expQ.push_back(4'h6);
    s_valid = 1'b1;
    s_data  = 1'b0;
    s_sof   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_stall_s_ready", 32'(s_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    checkOutput("bp_no_gap_valid", 32'(m_valid), 32'd1);
    checkOutput("bp_next_word", 32'(m_data), 32'h6);
    @(posedge clk);
    #1;

    // Realign: 1,1 then sof 0,1,1,1 -> one drop, word E (7 MSB-first).
    applyStimulus(1'b1, 1'b0, w);
    applyStimulus(1'b1, 1'b0, w);
    applyStimulus(1'b0, 1'b1, w);
    checkOutput("realign_drop", 32'(drop_cnt), 32'd1);
    applyStimulus(1'b1, 1'b0, w);
    applyStimulus(1'b1, 1'b0, w);
    expQ.push_back(pick(4'hE, 4'h7));
    applyStimulus(1'b1, 1'b0, w);

    // sof at a word boundary is just a normal first bit.
    applyStimulus(1'b1, 1'b1, w);
    checkOutput("sof_boundary_drop", 32'(drop_cnt), 32'd1);
    applyStimulus(1'b0, 1'b0, w);
    applyStimulus(1'b1, 1'b0, w);
    expQ.push_back(pick(4'h5, 4'hA));
    applyStimulus(1'b0, 1'b0, w);
    @(posedge clk);
    #1;
    checkOutput("sof_boundary_drop_after", 32'(drop_cnt), 32'd1);

    // Saturation: 300 two-bit partial words each cut short by sof.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, w);
      applyStimulus(1'b0, 1'b0, w);
    end
    applyStimulus(1'b1, 1'b1, w);
    checkOutput("drop_saturated", 32'(drop_cnt), 32'd255);
    applyStimulus(1'b0, 1'b0, w);
    applyStimulus(1'b1, 1'b1, w);
    checkOutput("drop_stays_saturated", 32'(drop_cnt), 32'd255);

    // Reset mid-word: partial word vanishes silently.
    applyStimulus(1'b1, 1'b0, w);
    applyStimulus(1'b1, 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_mid_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_after_valid", 32'(m_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, w);
    applyStimulus(1'b0, 1'b0, w);
    applyStimulus(1'b1, 1'b0, w);
    expQ.push_back(pick(4'h4, 4'h2));
    applyStimulus(1'b0, 1'b0, w);
    checkOutput("rst_word_valid", 32'(m_valid), 32'd1);
    checkOutput("rst_word_drop", 32'(drop_cnt), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
